bench_result_judge: RTL

Downstream stage of the benchmark controller. It collects the four per-condition cycle counts (Base-2, Base-10, Base-12, Router) as they are reported, then selects the fastest condition. It drives the one-hot winner LEDs and the RGB status LED, and holds the stored counts readable as stored_cond1..stored_cond4.

---
 rtl/bench_result_judge.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bench_result_judge.sv
// Result judge: collects four per-condition cycle counts, scans for the
// fastest non-zero one and drives the winner and status LEDs.
module bench_result_judge #(
   parameter int COUNT_W         = 32,
   parameter int RST_SHOW_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               bench_start,
   input  logic               cond_valid,
   input  logic [1:0]         cond_id,
   input  logic [COUNT_W-1:0] cond_cycles,
   output logic [3:0]         led,
   output logic [3:0]         rgb_led,
   output logic [COUNT_W-1:0] stored_cond1,
   output logic [COUNT_W-1:0] stored_cond2,
   output logic [COUNT_W-1:0] stored_cond3,
   output logic [COUNT_W-1:0] stored_cond4,
   output logic               judge_done,
   output logic               err
);

   typedef enum logic [2:0] {
      S_SHOW, S_IDLE, S_RUN, S_CMP, S_DONE
   } state_t;

   localparam logic [3:0] RGB_RED   = 4'b0100;
   localparam logic [3:0] RGB_OFF   = 4'b0000;
   localparam logic [3:0] RGB_BLUE  = 4'b0001;
   localparam logic [3:0] RGB_GREEN = 4'b0010;

   state_t             r_state;
   logic [31:0]        r_cnt;
   logic [31:0]        r_tmr;
   logic [3:0]         r_got;
   logic [1:0]         r_idx;
   logic [COUNT_W-1:0] r_min;
   logic [1:0]         r_win;
   logic               r_found;
   logic [3:0]         r_led;
   logic [3:0]         r_rgb;
   logic [COUNT_W-1:0] r_stored [4];
   logic               r_done;
   logic               r_err;

   logic               w_start;
   logic               w_tmo;
   logic [COUNT_W-1:0] w_cur;
   logic               w_take;
   logic [1:0]         w_win_n;
   logic               w_found_n;

   assign w_start = bench_start &&
                    (r_state == S_IDLE || r_state == S_RUN ||
                     r_state == S_DONE);
   assign w_tmo   = (TIMEOUT_CYCLES > 0) &&
                    (r_tmr == 32'(TIMEOUT_CYCLES - 1));

   // Zero means "not measured" and never wins; ties keep the lower index.
   assign w_cur     = r_stored[r_idx];
   assign w_take    = (w_cur != '0) && (!r_found || w_cur < r_min);
   assign w_win_n   = w_take ? r_idx : r_win;
   assign w_found_n = r_found | w_take;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_SHOW;
         r_cnt   <= '0;
         r_tmr   <= '0;
         r_got   <= '0;
         r_idx   <= '0;
         r_min   <= '0;
         r_win   <= '0;
         r_found <= 1'b0;
         r_led   <= '0;
         r_rgb   <= RGB_RED;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         for (int i = 0; i < 4; i++) r_stored[i] <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_start) begin
            r_state <= S_RUN;
            r_rgb   <= RGB_BLUE;
            r_tmr   <= '0;
            r_got   <= '0;
            r_led   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < 4; i++) r_stored[i] <= '0;
         end else begin
            unique case (r_state)
               S_SHOW: begin
                  if (r_cnt == 32'(RST_SHOW_CYCLES - 1)) begin
                     r_state <= S_IDLE;
                     r_rgb   <= RGB_OFF;
                  end else begin
                     r_cnt <= r_cnt + 32'd1;
                  end
               end
               S_RUN: begin
                  r_tmr <= r_tmr + 32'd1;
                  if (r_got == 4'hF) begin
                     r_state <= S_CMP;
                     r_idx   <= '0;
                     r_min   <= '0;
                     r_win   <= '0;
                     r_found <= 1'b0;
                  end else if (w_tmo) begin
                     r_state <= S_DONE;
                     r_rgb   <= RGB_GREEN;
                     r_led   <= '0;
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                  end else if (cond_valid) begin
                     if (r_got[cond_id]) begin
                        r_err <= 1'b1;
                     end else begin
                        r_stored[cond_id] <= cond_cycles;
                        r_got[cond_id]    <= 1'b1;
                     end
                  end
               end
               S_CMP: begin
                  r_idx   <= r_idx + 2'd1;
                  r_win   <= w_win_n;
                  r_found <= w_found_n;
                  if (w_take) r_min <= w_cur;
                  if (r_idx == 2'd3) begin
                     r_state <= S_DONE;
                     r_rgb   <= RGB_GREEN;
                     r_done  <= 1'b1;
                     r_led   <= w_found_n ? (4'b0001 << w_win_n) : 4'b0000;
                     if (!w_found_n) r_err <= 1'b1;
                  end
               end
               S_IDLE, S_DONE: ;
               default: r_state <= S_SHOW;
            endcase
         end
      end
   end

   assign led          = r_led;
   assign rgb_led      = r_rgb;
   assign stored_cond1 = r_stored[0];
   assign stored_cond2 = r_stored[1];
   assign stored_cond3 = r_stored[2];
   assign stored_cond4 = r_stored[3];
   assign judge_done   = r_done;
   assign err          = r_err;

endmodule
